// File: rtl/prefetch_buf.sv
// Instruction prefetch buffer: small circular FIFO of {instr, PC+2} pairs
// between fetch and decode, with flush for redirects and NOP when empty.
module prefetch_buf #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_PCplusTwo,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_PCplusTwo,
  output logic [2:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 3;

  logic [15:0]      r_instr [DEPTH];
  logic [15:0]      r_pc    [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  // Full/empty come only from the stored count, so in_ready never sees out_ready.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = in_valid & ~w_full & ~flush;
  assign w_deq   = out_ready & ~w_empty & ~flush;

  assign in_ready      = ~w_full;
  assign out_valid     = ~w_empty;
  assign out_instr     = w_empty ? NOP_INSTR : r_instr[r_rptr];
  assign out_PCplusTwo = w_empty ? 16'h0000  : r_pc[r_rptr];
  assign count         = r_count;

  // Storage: written on enqueue only; flush leaves stale words behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (w_enq) begin
      r_instr[r_wptr] <= in_instr;
      r_pc[r_wptr]    <= in_PCplusTwo;
    end
  end

  // Pointers and count; flush outranks enqueue and dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_buf.sv
// Self-checking bench for prefetch_buf: directed scenarios plus random traffic
// compared against a queue-based model of the buffer.
module tb_prefetch_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_PCplusTwo;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_PCplusTwo;
  logic [2:0]  count;

  int checks;
  int errors;

  logic [31:0] mq[$];

  prefetch_buf dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_PCplusTwo (in_PCplusTwo),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_PCplusTwo(out_PCplusTwo),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the FIFO.
  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk16({tag, ".count"}, 16'(count), 16'(n));
    chk1({tag, ".out_valid"}, out_valid, n != 0);
    chk1({tag, ".in_ready"}, in_ready, n != 4);
    chk16({tag, ".out_instr"}, out_instr, (n != 0) ? mq[0][31:16] : 16'h0800);
    chk16({tag, ".out_pc"}, out_PCplusTwo, (n != 0) ? mq[0][15:0] : 16'h0000);
  endtask

  // One clock: drive inputs, model the edge, check 1 time unit after it.
  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic r, input logic f, input string tag);
    int  n;
    logic enq;
    logic deq;
    in_valid     = v;
    in_instr     = ins;
    in_PCplusTwo = pc;
    out_ready    = r;
    flush        = f;
    @(posedge clk);
    n   = mq.size();
    enq = v && (n != 4) && !f;
    deq = r && (n != 0) && !f;
    if (f) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back({ins, pc});
    end
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset asserted mid-cycle and checked before the next edge.
  task automatic do_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    check_model({tag, ".async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model({tag, ".post"});
  endtask

  initial begin
    logic [15:0] exp_ord [6];
    int          idx;
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_instr     = '0;
    in_PCplusTwo = '0;
    out_ready    = 1'b0;
    exp_ord[0] = 16'h1001; exp_ord[1] = 16'h1002; exp_ord[2] = 16'h1003;
    exp_ord[3] = 16'h1004; exp_ord[4] = 16'h2001; exp_ord[5] = 16'h2002;

    @(posedge clk);
    #1;
    do_reset("reset");
    chk16("reset.nop_const", out_instr, 16'h0800);

    // Fill with five words; the fifth is dropped.
    for (int k = 1; k <= 5; k++)
      step(1'b1, 16'h1000 + 16'(k), 16'h0100 + 16'(2 * k), 1'b0, 1'b0, "fill");
    chk16("fill.count4", 16'(count), 16'd4);
    chk1("fill.in_ready0", in_ready, 1'b0);
    chk16("fill.head", out_instr, 16'h1001);

    // Drain two, refill two across the wrap, then drain in order.
    idx = 0;
    for (int k = 0; k < 2; k++) begin
      chk16("drain.order", out_instr, exp_ord[idx]);
      idx++;
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "drain");
    end
    step(1'b1, 16'h2001, 16'h0202, 1'b0, 1'b0, "wrap_enq");
    step(1'b1, 16'h2002, 16'h0204, 1'b0, 1'b0, "wrap_enq");
    while (idx < 6) begin
      chk16("drain.order", out_instr, exp_ord[idx]);
      idx++;
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "drain");
    end
    chk16("drain.empty_count", 16'(count), 16'd0);
    chk16("drain.empty_nop", out_instr, 16'h0800);

    // Simultaneous enqueue/dequeue at count 2.
    step(1'b1, 16'h3001, 16'h0302, 1'b0, 1'b0, "simul_pre");
    step(1'b1, 16'h3002, 16'h0304, 1'b0, 1'b0, "simul_pre");
    for (int k = 3; k <= 5; k++)
      step(1'b1, 16'h3000 + 16'(k), 16'h0300 + 16'(2 * k), 1'b1, 1'b0, "simul");
    chk16("simul.count2", 16'(count), 16'd2);
    chk16("simul.head", out_instr, 16'h3004);

    // Flush priority at count 3.
    step(1'b1, 16'h3006, 16'h030c, 1'b0, 1'b0, "flush_pre");
    chk16("flush_pre.count3", 16'(count), 16'd3);
    step(1'b1, 16'h4444, 16'h0444, 1'b1, 1'b1, "flush");
    chk1("flush.out_valid0", out_valid, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "flush_idle");

    // No-effect cases: dequeue while empty, enqueue while full.
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "empty_deq");
    for (int k = 0; k < 4; k++)
      step(1'b1, 16'h5000 + 16'(k), 16'h0500 + 16'(k), 1'b0, 1'b0, "refill");
    step(1'b1, 16'h5555, 16'h0555, 1'b0, 1'b0, "full_enq");
    chk16("full_enq.head", out_instr, 16'h5000);

    // Reset mid-operation discards all entries.
    do_reset("mid_reset");
    step(1'b1, 16'h6001, 16'h0602, 1'b0, 1'b0, "post_reset");

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 2) do_reset("rand_reset");
      else
        step(1'($urandom_range(0, 99) < 60), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
